// File: rtl/byte_sub_seq.sv
// Forward AES SubBytes engine: applies the FIPS-197 S-box to a 128-bit state, BYTES_PER_CYCLE bytes per clock.
// When count_in equals KEY_ROUND, the state is XORed with the round key (AddRoundKey) before substitution.
module byte_sub_seq #(
  parameter int unsigned BYTES_PER_CYCLE = 4,     // legal: 1, 2, 4, 8, 16
  parameter logic [3:0]  KEY_ROUND       = 4'd0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [3:0]   count_in,
  input  logic [127:0] key,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  // Forward S-box. Row r holds S(16*r) .. S(16*r+15); SBOX[0] is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // With 16 lanes the step wraps to 0, so the index stays at 0.
  localparam logic [3:0] STEP     = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] LAST_IDX = 4'(16 - BYTES_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;

  state_t            state_q;
  logic [3:0]        idx_q;
  logic [0:15][7:0]  work_q;     // byte 0 is bits [127:120]
  logic [0:15][7:0]  work_d;
  logic [127:0]      data_out_q;
  logic              busy_q;
  logic              done_q;
  logic              last_chunk;

  assign last_chunk = (idx_q == LAST_IDX);

  // One S-box lookup per lane, applied to the current chunk of the work register.
  always_comb begin
    // NOTE: assign the default first so every path writes work_d and no latch is inferred.
    work_d = work_q;
    for (int unsigned l = 0; l < BYTES_PER_CYCLE; l++) begin
      work_d[idx_q + 4'(l)] = SBOX[work_q[idx_q + 4'(l)]];
    end
  end

  // NOTE: all state uses non-blocking (<=) so each register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      // NOTE: work_q is a flop bank, not a memory array, so it takes the async reset too.
      work_q     <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            work_q  <= (count_in == KEY_ROUND) ? (data_in ^ key) : data_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SUB;
          end
        end
        S_SUB: begin
          work_q <= work_d;
          if (last_chunk) begin
            // Final chunk goes straight from the lanes into data_out: no extra cycle.
            data_out_q <= work_d;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            idx_q <= idx_q + STEP;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_byte_sub_seq.sv
// Self-checking bench for byte_sub_seq: three instances (4, 1 and 16 lanes) checked against a
// GF(2^8)-arithmetic model of SubBytes with optional AddRoundKey.
module tb_byte_sub_seq;

  localparam logic [3:0] KR = 4'd0;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [127:0] din, key_v;
  logic [3:0]   cnt;
  logic         start_r [3];
  logic [127:0] dout    [3];
  logic         busy_o  [3];
  logic         done_o  [3];

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  byte_sub_seq #(.BYTES_PER_CYCLE(4),  .KEY_ROUND(KR)) u_b4 (
    .clk(clk), .n_rst(n_rst), .start(start_r[0]), .data_in(din), .count_in(cnt), .key(key_v),
    .data_out(dout[0]), .busy(busy_o[0]), .done(done_o[0]));
  byte_sub_seq #(.BYTES_PER_CYCLE(1),  .KEY_ROUND(KR)) u_b1 (
    .clk(clk), .n_rst(n_rst), .start(start_r[1]), .data_in(din), .count_in(cnt), .key(key_v),
    .data_out(dout[1]), .busy(busy_o[1]), .done(done_o[1]));
  byte_sub_seq #(.BYTES_PER_CYCLE(16), .KEY_ROUND(KR)) u_b16 (
    .clk(clk), .n_rst(n_rst), .start(start_r[2]), .data_in(din), .count_in(cnt), .key(key_v),
    .data_out(dout[2]), .busy(busy_o[2]), .done(done_o[2]));

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : 1;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S(x) = affine(x^254) over GF(2^8) with the AES polynomial.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                         input logic [3:0] c);
    logic [127:0] w = (c == KR) ? (d ^ k) : d;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb[w[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    din   = rnd128();
    key_v = rnd128();
    cnt   = 4'($urandom_range(0, 15));
  endtask

  // Call at a negedge with instance k idle; returns at the negedge after the done cycle.
  task automatic run_op(input int k, input logic [127:0] d, input logic [127:0] kk,
                        input logic [3:0] c, input string tag);
    logic [127:0] exp_v, prev;
    int j;
    exp_v = model(d, kk, c);
    prev  = dout[k];
    din = d; key_v = kk; cnt = c; start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
    j = 0;
    while (!done_o[k] && j < 40) begin
      check({tag, " busy"}, 128'(busy_o[k]), 128'd1);
      check({tag, " hold"}, dout[k], prev);
      scramble();
      @(negedge clk);
      j++;
    end
    check({tag, " latency"}, 128'(j), 128'(n_of(k)));
    check({tag, " data"}, dout[k], exp_v);
    check({tag, " busy_at_done"}, 128'(busy_o[k]), 128'd0);
    @(negedge clk);
    check({tag, " done_pulse"}, 128'(done_o[k]), 128'd0);
    check({tag, " keep"}, dout[k], exp_v);
  endtask

  initial begin
    logic [127:0] d, exp_v, cur;
    int nd, last, keep;

    build_sbox();
    n_rst = 1'b0;
    for (int k = 0; k < 3; k++) start_r[k] = 1'b0;
    din = '0; key_v = '0; cnt = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      check("reset data", dout[k], 128'h0);
      check("reset busy", 128'(busy_o[k]), 128'd0);
      check("reset done", 128'(done_o[k]), 128'd0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Zero state, no key round: every byte becomes 0x63.
    run_op(0, 128'h0, rnd128(), 4'd5, "zero");
    check("zero const", dout[0], {16{8'h63}});

    // FIPS-197 Appendix B, first round with key XOR.
    run_op(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
           4'd0, "fips_key");
    check("fips_key const", dout[0], 128'hd42711aee0bf98f1b8b45de51e415230);

    // Same pre-XORed state on a later round: key must be ignored.
    run_op(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, {128{1'b1}}, 4'd1, "fips_nokey");
    check("fips_nokey const", dout[0], 128'hd42711aee0bf98f1b8b45de51e415230);

    // Asynchronous reset two chunks into an operation.
    din = rnd128(); key_v = rnd128(); cnt = 4'd3; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("abort data", dout[0], 128'h0);
    check("abort busy", 128'(busy_o[0]), 128'd0);
    check("abort done", 128'(done_o[0]), 128'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort no_done", 128'(done_o[0]), 128'd0);
      check("abort no_update", dout[0], 128'h0);
    end

    // Randomized operations on every instance, some on the key round.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 4; t++) begin
        run_op(k, rnd128(), rnd128(), (t % 2 == 0) ? KR : 4'($urandom_range(0, 15)), "random");
      end
    end

    // Byte spot checks with 1 and 16 lanes.
    for (int k = 1; k < 3; k++) begin
      d = rnd128();
      d[127:104] = 24'h0053ff;
      run_op(k, d, rnd128(), 4'd7, "spot");
      check("spot byte0", 128'(dout[k][127:120]), 128'h63);
      check("spot byte1", 128'(dout[k][119:112]), 128'hed);
      check("spot byte2", 128'(dout[k][111:104]), 128'h16);
    end

    // start held high: one result every N+2 cycles; inputs scrambled during SUB.
    din = rnd128(); key_v = rnd128(); cnt = 4'($urandom_range(0, 1));
    exp_v = model(din, key_v, cnt);
    cur = dout[0];
    start_r[0] = 1'b1;
    nd = 0; last = -1; keep = 0;
    for (int cyc = 0; cyc < 60 && nd < 4; cyc++) begin
      @(negedge clk);
      check("stream overlap", 128'(busy_o[0] & done_o[0]), 128'd0);
      if (done_o[0]) begin
        check("stream data", dout[0], exp_v);
        if (last >= 0) check("stream interval", 128'(cyc - last), 128'd6);
        last = cyc; nd++; cur = exp_v;
        din = rnd128(); key_v = rnd128(); cnt = 4'($urandom_range(0, 1));
        exp_v = model(din, key_v, cnt);
        keep = 1;
      end else begin
        check("stream stable", dout[0], cur);
        if (keep > 0) keep--;
        else scramble();
      end
    end
    check("stream count", 128'(nd), 128'd4);
    start_r[0] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_sub_seq.md
Name: byte_sub_seq

Overview:
- Forward (encryption) SubBytes engine. It is the counterpart of the decryption inverse-substitution stage.
- Substitutes the 128-bit AES state through the forward S-box (FIPS-197), a few bytes per clock, under a start/done handshake.
- On the initial round it first applies AddRoundKey (state ^ key), mirroring the decrypt side's final-round key XOR.
- Sits in the encryption datapath between the round-key XOR and ShiftRows; driven by the round controller.

Parameters:
- BYTES_PER_CYCLE, 4, number of S-box lanes; legal values 1, 2, 4, 8, 16.
- KEY_ROUND, 0, value of count_in for which data_in ^ key is substituted instead of data_in.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- data_in  input  128  state to substitute; FIPS byte 0 = [127:120], byte 15 = [7:0].
- count_in  input  4  round number, sampled with start.
- key  input  128  round key, sampled with start.
- data_out  output  128  registered substituted state; holds last result.
- busy  output  1  high while in SUB.
- done  output  1  one-cycle pulse when data_out is updated.

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, byte index=0, work register=0.
  - data_out=0, busy=0, done=0.
  - Reset mid-operation aborts with no done pulse and no partial update of data_out.
- Let N = 16/BYTES_PER_CYCLE.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - On start=1 at an edge, latch work = (count_in==KEY_ROUND) ? data_in^key : data_in.
  - Clear index; go to SUB.
  - data_in, key and count_in are not looked at after this edge.
- SUB:
  - Each edge replaces bytes index..index+B-1 of work (byte 0 first) with S(byte), then index += B.
  - On the edge that processes the last chunk: data_out <= the fully substituted word, index wraps to 0, go to DONE.
  - busy=1 throughout SUB.
- DONE:
  - done=1 for exactly this one cycle, busy=0; next edge returns to IDLE.
- Latency: start sampled at edge E0; data_out valid and done=1 in the cycle after edge EN.
  - With B=4: 4 cycles; with B=16: 1 cycle.
- start is ignored in SUB and DONE; it is not queued. Back-to-back throughput is therefore one result per N+2 cycles.
- data_out changes only on the final SUB edge; it is stable at all other times, including while a new operation is in progress.
- The S-box is a pure combinational lookup (256-entry forward table), one instance per lane.
- The last chunk is written into data_out directly from the S-box outputs, so there is no extra cycle.
- KEY_ROUND comparison is 4-bit equality. count_in values 10–15 are legal and simply select no XOR unless KEY_ROUND equals them.
- done and busy are never high simultaneously.

Test Plan:
1. Reset with n_rst=0 asynchronously mid-SUB (B=4, after 2 chunks) -> data_out=0, busy=0, done=0 immediately; no done pulse after release.
2. data_in=128'h0, count_in=5, start one cycle (B=4):
   - busy high 4 cycles, then done pulse.
   - data_out=128'h6363...63 (all 16 bytes 0x63).
3. FIPS-197 App. B, count_in=0, data_in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> data_out=d42711aee0bf98f1b8b45de51e415230 after 4 cycles.
4. Same data_in=193de3bea0f4e22b9ac68d2ae9f84808 with count_in=1, key=all-ones -> key ignored; data_out=d42711aee0bf98f1b8b45de51e415230.
5. start held high continuously:
   - results separated by N+2 cycles.
   - inputs changed during SUB do not affect the result.
   - data_out stable between done pulses.
6. Byte spot checks with B=1 and B=16, data_in bytes {00,53,FF,...}:
   - corresponding output bytes {63,ED,16}.
   - latency 16 cycles and 1 cycle respectively.
